// File: rtl/fetch_sequencer_pkg.sv
// rtl/fetch_sequencer_pkg.sv - fetch sequencer state encodings and reset PC
package fetch_sequencer_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_FETCH = 3'd1,
        ST_HOLD  = 3'd2,
        ST_FLUSH = 3'd3,
        ST_HALT  = 3'd4
    } fetch_state_t;

    localparam int RESET_PC = 0;

    function automatic logic is_busy(input fetch_state_t st);
        return (st == ST_FETCH) || (st == ST_HOLD) || (st == ST_FLUSH);
    endfunction

endpackage

// File: rtl/fetch_sequencer.sv
// rtl/fetch_sequencer.sv - PC next-value mux and instruction fetch req/ack sequencer
module fetch_sequencer
    import fetch_sequencer_pkg::*;
#(
    parameter int AW = 11,
    parameter int IW = 32
) (
    input  logic          i_clk,
    input  logic          i_rst_n,
    input  logic          i_start,
    input  logic [AW-1:0] i_pc_cur,
    output logic [AW-1:0] o_pc_next,
    output logic          o_imem_req,
    output logic [AW-1:0] o_imem_addr,
    input  logic          i_imem_ack,
    input  logic [IW-1:0] i_imem_data,
    output logic [IW-1:0] o_instr_out,
    output logic          o_instr_valid,
    input  logic          i_decode_ready,
    input  logic          i_redirect_valid,
    input  logic [AW-1:0] i_redirect_target,
    input  logic          i_halt_req,
    output logic          o_busy,
    output logic          o_halted
);

    fetch_state_t  r_state;
    fetch_state_t  w_state_nxt;
    logic [AW-1:0] r_addr;
    logic [IW-1:0] r_instr;
    logic          r_instr_valid;
    logic [AW-1:0] w_pc_next;
    logic          w_enter_fetch;
    logic          w_load_instr;
    logic          w_clr_valid;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state       <= ST_IDLE;
            r_addr        <= AW'(RESET_PC);
            r_instr       <= '0;
            r_instr_valid <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            // The fetch address is captured once per request so it stays stable until ack.
            if (w_enter_fetch) begin
                r_addr <= w_pc_next;
            end
            if (w_load_instr) begin
                r_instr       <= i_imem_data;
                r_instr_valid <= 1'b1;
            end else if (w_clr_valid) begin
                r_instr_valid <= 1'b0;
            end
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_pc_next     = i_pc_cur;
        w_enter_fetch = 1'b0;
        w_load_instr  = 1'b0;
        w_clr_valid   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (i_start) begin
                    w_state_nxt   = ST_FETCH;
                    w_enter_fetch = 1'b1;
                end
            end
            ST_FETCH: begin
                if (i_imem_ack && i_redirect_valid) begin
                    w_pc_next     = i_redirect_target;
                    w_enter_fetch = 1'b1;
                end else if (i_imem_ack) begin
                    w_pc_next    = i_pc_cur + AW'(1);
                    w_load_instr = 1'b1;
                    w_state_nxt  = ST_HOLD;
                end else if (i_redirect_valid) begin
                    w_pc_next   = i_redirect_target;
                    w_state_nxt = ST_FLUSH;
                end
            end
            ST_FLUSH: begin
                // Old request must complete before the redirected fetch is issued.
                if (i_redirect_valid) begin
                    w_pc_next = i_redirect_target;
                end
                if (i_imem_ack) begin
                    w_state_nxt   = ST_FETCH;
                    w_enter_fetch = 1'b1;
                end
            end
            ST_HOLD: begin
                if (i_redirect_valid || i_decode_ready) begin
                    w_clr_valid = 1'b1;
                    if (i_redirect_valid) begin
                        w_pc_next = i_redirect_target;
                    end
                    if (i_decode_ready && i_halt_req) begin
                        w_state_nxt = ST_HALT;
                    end else begin
                        w_state_nxt   = ST_FETCH;
                        w_enter_fetch = 1'b1;
                    end
                end
            end
            ST_HALT: begin
                if (i_start) begin
                    w_state_nxt   = ST_FETCH;
                    w_enter_fetch = 1'b1;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    assign o_pc_next     = w_pc_next;
    assign o_imem_req    = (r_state == ST_FETCH) || (r_state == ST_FLUSH);
    assign o_imem_addr   = r_addr;
    assign o_instr_out   = r_instr;
    assign o_instr_valid = r_instr_valid;
    assign o_busy        = is_busy(r_state);
    assign o_halted      = (r_state == ST_HALT);

endmodule
